// File: rtl/ysyx_23060337_ifu_pkg.sv
// Shared definitions for the ysyx_23060337 instruction fetch unit:
// FSM state encoding, reset PC, canonical NOP and the fetch increment.
package ysyx_23060337_ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] INST_LEN         = 32'd4;

endpackage

// File: rtl/ysyx_23060337_ifu.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory and hands each instruction to decode; redirects win.
module ysyx_23060337_ifu
  import ysyx_23060337_ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     fetch_count
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [31:0]     inst_q, inst_d;
  logic            fault_q, fault_d;
  logic [31:0]     count_q, count_d;

  logic [XLEN-1:0] redirect_target;
  logic            req_fire;
  logic            inst_fire;

  assign redirect_target = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
  assign req_fire        = imem_req_valid & imem_req_ready;
  assign inst_fire       = inst_valid & inst_ready;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      inst_q  <= 32'd0;
      fault_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath update; a redirect overrides every other event.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) begin
          pc_d = redirect_target;
        end else begin
          pc_d = pc_q;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
          if (req_fire) begin
            // The request already left with the old address: kill its response.
            drop_d  = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = REQ;
          end
        end else if (req_fire) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
          if (imem_resp_valid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d  = imem_resp_data;
            fault_d = imem_resp_err;
            state_d = HOLD;
          end
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = REQ;
        end else if (inst_fire) begin
          pc_d    = pc_q + XLEN'(INST_LEN);
          count_d = count_q + 32'd1;
          state_d = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    case (state_q)
      REQ:  imem_req_valid = 1'b1;
      HOLD: inst_valid     = ~redirect_valid;
      default: begin
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
      end
    endcase
    imem_req_addr = pc_q;
    inst          = inst_q;
    inst_pc       = pc_q;
    inst_fault    = fault_q;
    fetch_count   = count_q;
  end

endmodule

// File: tb/tb_ysyx_23060337_ifu.sv
// Bench for ysyx_23060337_ifu: a one-outstanding memory responder plus a
// program-order model of which PC decode should see next.
module tb_ysyx_23060337_ifu;
  import ysyx_23060337_ifu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid, imem_resp_err;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready, inst_fault;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  ysyx_23060337_ifu #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_count(fetch_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory contents: the first three words are NOPs, the rest a hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= RST_PC && a < RST_PC + 32'd12) return NOP;
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[7:2] == 6'h04;
  endfunction

  // Drive requests for the coming cycle
  bit          d_rst = 1'b1, d_redir = 1'b0, d_iready = 1'b0, d_rready = 1'b0, d_spur = 1'b0;
  logic [31:0] d_rpc = 32'd0;
  int          lat_fixed = 0;
  bit          lat_rand = 1'b0;
  bit          force_en = 1'b0;
  logic [31:0] force_data = 32'd0;

  // Responder and reference model state
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  int          pend_cnt = 0;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] exp_cnt = 32'd0;
  bit          hold_prev = 1'b0;
  logic [31:0] prev_inst = 32'd0;

  // Observations of the last cycle
  bit          o_fire, o_hs, o_req_valid, o_inst_valid, o_fault;
  logic [31:0] o_addr, o_inst, o_pc, o_count;

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    imem_resp_err = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
  end

  task automatic step();
    @(negedge clk);
    rst = d_rst; redirect_valid = d_redir; redirect_pc = d_rpc;
    inst_ready = d_iready; imem_req_ready = d_rready;
    if (pend && pend_cnt == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = force_en ? force_data : mem_word(pend_addr);
      imem_resp_err   = mem_err(pend_addr);
      force_en        = 1'b0;
    end else if (!pend && d_spur) begin
      imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_0BAD; imem_resp_err = 1'b1;
    end else begin
      imem_resp_valid = 1'b0; imem_resp_data = 32'd0; imem_resp_err = 1'b0;
    end
    #1;
    o_req_valid = imem_req_valid; o_inst_valid = inst_valid; o_fault = inst_fault;
    o_addr = imem_req_addr; o_inst = inst; o_pc = inst_pc; o_count = fetch_count;
    o_fire = imem_req_valid && imem_req_ready;
    o_hs   = inst_valid && inst_ready;
    if (d_rst) begin
      exp_pc = RST_PC; exp_cnt = 32'd0; hold_prev = 1'b0;
    end else begin
      chk("fetch_count", fetch_count, exp_cnt);
      if (d_redir) chk("valid_on_redirect", 32'(inst_valid), 32'd0);
      if (hold_prev && !d_redir) begin
        chk("hold_valid", 32'(inst_valid), 32'd1);
        chk("hold_inst", inst, prev_inst);
      end
      if (inst_valid) begin
        chk("inst_pc", inst_pc, exp_pc);
        chk("inst", inst, mem_word(exp_pc));
        chk("inst_fault", 32'(inst_fault), 32'(mem_err(exp_pc)));
      end
      if (o_fire) begin
        chk("req_addr", imem_req_addr, exp_pc);
        chk("one_outstanding", 32'(pend), 32'd0);
      end
      hold_prev = inst_valid && !inst_ready;
      prev_inst = inst;
      if (o_hs) begin
        exp_pc  = exp_pc + 32'd4;
        exp_cnt = exp_cnt + 32'd1;
      end
      if (d_redir) exp_pc = d_rpc & 32'hFFFF_FFFC;
    end
    if (pend && pend_cnt == 0) pend = 1'b0;
    else if (pend) pend_cnt--;
    if (o_fire) begin
      pend      = 1'b1;
      pend_addr = imem_req_addr;
      pend_cnt  = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
    end
  endtask

  // kind: 0 request fire, 1 decode handshake, 2 inst_valid
  task automatic wait_ev(input int kind, input string tag);
    int  n = 0;
    bit  hit;
    do begin
      step();
      n++;
      hit = (kind == 0) ? o_fire : (kind == 1) ? o_hs : o_inst_valid;
    end while (!hit && n < 40);
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic do_reset();
    d_rst = 1'b1; d_redir = 1'b0; d_rready = 1'b0; d_iready = 1'b0; d_spur = 1'b0;
    repeat (5) step();
    d_rst = 1'b0;
  endtask

  logic [31:0] fires[$];
  int          hs_at[$];
  logic [31:0] saved_pc, saved_cnt;
  int          hs_total = 0;

  initial begin
    // Basic stream with zero-latency memory
    do_reset();
    chk("rst_req_valid", 32'(o_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(o_inst_valid), 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_inst_pc", o_pc, RST_PC);
    chk("rst_inst_fault", 32'(o_fault), 32'd0);
    lat_fixed = 0; d_rready = 1'b1; d_iready = 1'b1;
    step();
    chk("idle_no_req", 32'(o_req_valid), 32'd0);
    for (int i = 0; i < 9; i++) begin
      step();
      if (o_fire) fires.push_back(o_addr);
      if (o_hs) hs_at.push_back(i);
    end
    chk("t1_nfires", 32'(fires.size()), 32'd3);
    chk("t1_nhs", 32'(hs_at.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_addr", (k < fires.size()) ? fires[k] : 32'hFFFF_FFFF, RST_PC + 32'(4 * k));
      chk("t1_hs_cycle", (k < hs_at.size()) ? 32'(hs_at[k]) : 32'hFFFF_FFFF, 32'(2 + 3 * k));
    end
    step();
    chk("t1_count", o_count, 32'd3);

    // Decode stall in HOLD
    d_iready = 1'b0;
    wait_ev(2, "t2_valid");
    saved_pc = o_pc;
    repeat (5) begin
      step();
      chk("t2_no_req", 32'(o_req_valid), 32'd0);
      chk("t2_stable_pc", o_pc, saved_pc);
    end
    d_iready = 1'b1;
    step();
    chk("t2_hs", 32'(o_hs), 32'd1);
    step();
    chk("t2_next_req", 32'(o_fire), 32'd1);
    chk("t2_next_addr", o_addr, saved_pc + 32'd4);

    // Redirect while waiting, stale 0xdeadbeef returns later
    lat_fixed = 2;
    wait_ev(0, "t3_fire");
    d_redir = 1'b1; d_rpc = 32'h8000_0100; force_en = 1'b1; force_data = 32'hDEAD_BEEF;
    step();
    d_redir = 1'b0; lat_fixed = 0;
    wait_ev(0, "t3_refire");
    chk("t3_addr", o_addr, 32'h8000_0100);

    // Redirect in HOLD with decode ready in the same cycle
    d_iready = 1'b0;
    wait_ev(2, "t4_valid");
    saved_cnt = o_count;
    d_redir = 1'b1; d_rpc = 32'h8000_0203; d_iready = 1'b1;
    step();
    chk("t4_valid_low", 32'(o_inst_valid), 32'd0);
    d_redir = 1'b0;
    wait_ev(0, "t4_fire");
    chk("t4_addr", o_addr, 32'h8000_0200);
    chk("t4_count", o_count, saved_cnt);

    // Faulting fetch
    d_redir = 1'b1; d_rpc = 32'h8000_0010;
    step();
    d_redir = 1'b0;
    wait_ev(1, "t5_hs");
    chk("t5_fault", 32'(o_fault), 32'd1);
    chk("t5_pc", o_pc, 32'h8000_0010);
    wait_ev(0, "t5_fire");
    chk("t5_next_addr", o_addr, 32'h8000_0014);

    // PC wraps at the top of the address space
    d_redir = 1'b1; d_rpc = 32'hFFFF_FFFD;
    step();
    d_redir = 1'b0;
    wait_ev(1, "wrap_hs");
    chk("wrap_pc", o_pc, 32'hFFFF_FFFC);
    wait_ev(0, "wrap_fire");
    chk("wrap_addr", o_addr, 32'h0000_0000);

    // Reset in WAIT with the response landing one cycle later
    lat_fixed = 1;
    wait_ev(0, "t6_fire");
    d_rst = 1'b1; d_rready = 1'b0;
    step();
    d_rst = 1'b0;
    step();
    chk("t6_idle", 32'(o_req_valid), 32'd0);
    d_rready = 1'b1; lat_fixed = 0;
    wait_ev(0, "t6_refire");
    chk("t6_addr", o_addr, RST_PC);
    chk("t6_count", o_count, 32'd0);
    wait_ev(1, "t6_hs");
    chk("t6_inst", o_inst, NOP);

    // Randomized traffic
    lat_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      d_rready = ($urandom_range(0, 9) < 6);
      d_iready = ($urandom_range(0, 9) < 7);
      d_redir  = ($urandom_range(0, 15) == 0);
      d_rpc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : (RST_PC + 32'($urandom_range(0, 1023)));
      d_spur   = ($urandom_range(0, 19) == 0);
      step();
      if (o_hs) hs_total++;
    end
    chk("rand_progress", 32'(hs_total > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
